// File: rtl/operand_accumulator_pkg.sv
// Shared definitions for the operand accumulator: FSM state encoding and
// default width constants.
package operand_accumulator_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_ACC_W  = 8;
  localparam int unsigned DEF_CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/operand_accumulator_acc_add.sv
// Combinational ACC_W-bit adder with carry-in and carry-out, used by the
// accumulator datapath.
module acc_add
  import operand_accumulator_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             cin,
  output logic [ACC_W-1:0] sum,
  output logic             cout
);

  logic [ACC_W:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {{ACC_W{1'b0}}, cin};
  assign sum    = w_full[ACC_W-1:0];
  assign cout   = w_full[ACC_W];

endmodule

// File: rtl/operand_accumulator.sv
// Accumulates a burst of unsigned operands (terminated by in_last) and
// presents total, saturating operand count and overflow flag on a
// valid/ready result port.
module operand_accumulator
  import operand_accumulator_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_t             r_state;
  state_t             w_next;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic [ACC_W-1:0]   w_data_ext;
  logic [ACC_W-1:0]   w_sum;
  logic               w_cout;
  logic               w_in_fire;

  assign w_data_ext = {{(ACC_W-DATA_W){1'b0}}, in_data};
  assign w_in_fire  = in_valid & in_ready;

  acc_add #(
    .ACC_W (ACC_W)
  ) u_acc_add (
    .a    (r_acc),
    .b    (w_data_ext),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_in_fire) begin
          w_next = in_last ? OUT : ACC;
        end
      end
      ACC: begin
        if (w_in_fire && in_last) begin
          w_next = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs are gated by rst_n so nothing is offered while reset
  // is held, whatever state the register still holds.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE, ACC: in_ready  = rst_n;
      OUT:       out_valid = rst_n;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign out_sum   = out_valid ? r_acc : '0;
  assign out_count = out_valid ? r_cnt : '0;
  assign out_ovf   = out_valid & r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_in_fire) begin
      if (r_state == IDLE) begin
        r_acc <= w_data_ext;
        r_cnt <= CNT_W'(1);
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_sum;
        if (r_cnt != '1) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        r_ovf <= r_ovf | w_cout;
      end
    end
  end

endmodule
